// File: rtl/ctrl_pkg.sv
// Shared encodings for the datapath control stage.
//   op_t    : opcode presented with start
//   state_t : sequencer FSM state, 2-bit binary
package ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LOAD_A = 2'b00,
    OP_MOV_AB = 2'b01,
    OP_ADD    = 2'b10,
    OP_ACC    = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_T0   = 2'b01,
    S_T1   = 2'b10,
    S_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/bus_sequencer.sv
// Control sequencer for the 32-bit register/adder datapath.
// Accepts a one-cycle start with an opcode and an ACC iteration count, then
// steps the register-load strobes and the one-hot bus-drive strobes.
// Ports:
//   clock, clear          : clock, async active-low reset
//   start, op, iter       : request, opcode, ACC repeat count (sampled in IDLE)
//   RAin, RBin, RZin      : register load strobes
//   RAout, RBout, RZout   : bus drive strobes (at most one high)
//   busy, done            : not-idle flag, one-cycle completion pulse
module bus_sequencer
  import ctrl_pkg::*;
#(
  parameter int ITER_W = 8
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ITER_W-1:0] iter,
  output logic              RAin,
  output logic              RBin,
  output logic              RZin,
  output logic              RAout,
  output logic              RBout,
  output logic              RZout,
  output logic              busy,
  output logic              done
);

  state_t            state, nxt;
  op_t               op_q;
  logic [ITER_W-1:0] cnt;

  // State register, latched opcode and ACC down-counter.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= S_IDLE;
      op_q  <= OP_LOAD_A;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && start) begin
        op_q <= op_t'(op);
        cnt  <= iter;
      end else if (state == S_T1 && op_q == OP_ACC) begin
        // cnt >= 1 here: a zero count never reaches T1.
        cnt <= cnt - ITER_W'(1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (op_t'(op) == OP_ACC && iter == '0) nxt = S_DONE;
          else                                   nxt = S_T0;
        end
      end
      S_T0: begin
        if (op_q == OP_ADD || op_q == OP_ACC) nxt = S_T1;
        else                                  nxt = S_DONE;
      end
      S_T1: begin
        // Last ACC pass is the one that brings the count to zero.
        if (op_q == OP_ACC && cnt != ITER_W'(1)) nxt = S_T0;
        else                                     nxt = S_DONE;
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state and latched opcode only.
  always_comb begin
    RAin  = 1'b0;
    RBin  = 1'b0;
    RZin  = 1'b0;
    RAout = 1'b0;
    RBout = 1'b0;
    RZout = 1'b0;
    busy  = (state != S_IDLE);
    done  = (state == S_DONE);
    unique case (state)
      S_T0: begin
        unique case (op_q)
          OP_LOAD_A: RAin = 1'b1;
          OP_MOV_AB: begin RAout = 1'b1; RBin = 1'b1; end
          OP_ADD:    begin RAout = 1'b1; RZin = 1'b1; end
          OP_ACC:    begin RBout = 1'b1; RZin = 1'b1; end
          default: ;
        endcase
      end
      S_T1: begin
        if (op_q == OP_ADD || op_q == OP_ACC) begin
          RZout = 1'b1;
          RBin  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_sequencer.sv
module tb_bus_sequencer;

  localparam int ITER_W = 8;

  // Expected output vectors: {RAin,RBin,RZin,RAout,RBout,RZout,busy,done}
  localparam logic [7:0] V_LOADA  = 8'b1000_0010;
  localparam logic [7:0] V_MOV    = 8'b0101_0010;
  localparam logic [7:0] V_ADD_T0 = 8'b0011_0010;
  localparam logic [7:0] V_ACC_T0 = 8'b0010_1010;
  localparam logic [7:0] V_T1     = 8'b0100_0110;
  localparam logic [7:0] V_DONE   = 8'b0000_0011;

  logic              clock = 1'b0;
  logic              clear = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        op = 2'b00;
  logic [ITER_W-1:0] iter = '0;
  logic RAin, RBin, RZin, RAout, RBout, RZout, busy, done;

  bus_sequencer #(.ITER_W(ITER_W)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .iter(iter),
    .RAin(RAin), .RBin(RBin), .RZin(RZin),
    .RAout(RAout), .RBout(RBout), .RZout(RZout),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  logic [7:0] obs;
  assign obs = {RAin, RBin, RZin, RAout, RBout, RZout, busy, done};

  typedef struct {
    logic [7:0]  vec;
    bit          chk_rb;
    logic [31:0] rb;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   rand_mode = 1'b0;

  // Datapath model driven by the DUT strobes.
  logic [31:0] a_imm = 0, ra = 0, rb = 0, rz = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] v, input bit c = 0, input logic [31:0] r = 0);
    exp_t e;
    e.vec = v; e.chk_rb = c; e.rb = r;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: one entry per busy cycle, idle cycles must be quiet.
  always @(negedge clock) begin
    if (!rand_mode && clear) begin
      logic [31:0] bus;
      bus = RAout ? ra : RBout ? rb : RZout ? rz : 32'h0;
      if (RAin) ra = a_imm;
      if (RZin) rz = a_imm + bus;
      if (RBin) rb = bus;
      if (busy) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_busy: got %b expected idle at %0t", obs, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("cycle_vec", {24'h0, obs}, {24'h0, e.vec});
          if (e.chk_rb) check("final_rb", rb, e.rb);
        end
      end else begin
        check("idle_vec", {24'h0, obs}, 32'h0);
      end
    end
  end

  // Invariant monitor for the random phase.
  logic prev_done = 1'b0;
  always @(negedge clock) begin
    if (rand_mode) begin
      check("bus_onehot", {30'h0, 2'(int'(RAout) + int'(RBout) + int'(RZout) > 1)}, 32'h0);
      check("in_onehot", {30'h0, 2'(int'(RAin) + int'(RBin) + int'(RZin) > 1)}, 32'h0);
      check("done_twice", {31'h0, done & prev_done}, 32'h0);
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clock); #2;
      if (sb.size() == 0 && !busy) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Issue one start; op/iter are scrambled right after the start edge.
  task automatic issue(input logic [1:0] o, input logic [ITER_W-1:0] n, input logic [31:0] a);
    @(posedge clock); #1;
    a_imm = a; start = 1'b1; op = o; iter = n;
    @(posedge clock); #1;
    start = 1'b0; op = ~o; iter = ITER_W'($urandom);
  endtask

  initial begin
    // Reset for two cycles.
    clear = 1'b0;
    repeat (2) @(posedge clock);
    #1 check("reset_vec", {24'h0, obs}, 32'h0);
    clear = 1'b1;
    @(negedge clock);
    check("post_reset_vec", {24'h0, obs}, 32'h0);

    // LOAD_A RA=7, then ADD with A=5 -> RB=12.
    push(V_LOADA); push(V_DONE);
    issue(2'b00, 8'd0, 32'd7);
    wait_idle("load_a");
    push(V_ADD_T0); push(V_T1); push(V_DONE, 1, 32'd12);
    issue(2'b10, 8'd0, 32'd5);
    wait_idle("add");

    // RB=10 via LOAD_A + MOV_AB, then ACC x3 with A=4 -> RB=22.
    push(V_LOADA); push(V_DONE);
    issue(2'b00, 8'd0, 32'd10);
    wait_idle("load_a2");
    push(V_MOV); push(V_DONE, 1, 32'd10);
    issue(2'b01, 8'd0, 32'd10);
    wait_idle("mov_ab");
    for (int i = 0; i < 3; i++) begin push(V_ACC_T0); push(V_T1); end
    push(V_DONE, 1, 32'd22);
    issue(2'b11, 8'd3, 32'd4);
    wait_idle("acc3");

    // ACC with iter=0: straight to DONE, RB untouched.
    push(V_DONE, 1, 32'd22);
    issue(2'b11, 8'd0, 32'd4);
    wait_idle("acc0");

    // start held 10 edges with MOV_AB: accepted on edges 0,3,6,9.
    for (int i = 0; i < 4; i++) begin push(V_MOV); push(V_DONE, 1, 32'd10); end
    @(posedge clock); #1;
    start = 1'b1; op = 2'b01; iter = 8'd0;
    repeat (10) @(posedge clock);
    #1 start = 1'b0;
    wait_idle("held_start");

    // Abort an ADD in T1: outputs drop before the next edge, no done follows.
    push(V_ADD_T0); push(V_T1); push(V_DONE);
    issue(2'b10, 8'd0, 32'd1);
    @(posedge clock); #2;
    clear = 1'b0;
    #1 check("abort_vec", {24'h0, obs}, 32'h0);
    sb.delete();
    @(posedge clock); #1 clear = 1'b1;
    repeat (4) @(posedge clock);

    // Recovery: ADD A=1 with RA=10 -> RB=11.
    push(V_ADD_T0); push(V_T1); push(V_DONE, 1, 32'd11);
    issue(2'b10, 8'd0, 32'd1);
    wait_idle("add_after_abort");

    // Random stimulus with random async resets, invariants only.
    rand_mode = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clock); #1;
      if (!clear) clear = 1'b1;
      start = 1'($urandom_range(0, 1));
      op    = 2'($urandom);
      iter  = ITER_W'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) begin
        #2 clear = 1'b0;
        #1 check("rand_reset_vec", {24'h0, obs}, 32'h0);
      end
    end
    @(posedge clock); #1;
    start = 1'b0; clear = 1'b0;
    @(posedge clock); #1;
    rand_mode = 1'b0;
    sb.delete();
    clear = 1'b1;
    repeat (2) @(posedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
